m_cond_issue: RTL and testbench

Issue sequencer between the instruction decoder and the execute stage. It buffers decoded instructions in a 2-entry FIFO and evaluates each instruction's condition field against the architectural NZCV flags. It forwards passing instructions to execute and squashes failing ones. It stalls conditional instructions while any issued flag-setting instruction has not yet written back its flags.

---
 rtl/m_cond_issue.sv | 150 +++++++++++++++
 tb/tb_m_cond_issue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_cond_issue.sv
// Issue sequencer: a 2-entry instruction FIFO whose head is checked against NZCV.
// Passing heads go to execute, failing heads are squashed, and conditional heads wait on pending flag writes.
package m_cond_issue_pkg;
    typedef enum logic [2:0] {
        K_ALU    = 3'd0,
        K_MUL    = 3'd1,
        K_LDST   = 3'd2,
        K_BRANCH = 3'd3,
        K_SYS    = 3'd4
    } e_kind;

    typedef enum logic [3:0] {
        C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
        C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
        C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
        C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
    } e_cond;
endpackage

module m_cond_issue
    import m_cond_issue_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  e_kind       in_kind,
    input  e_cond       in_cond,
    input  logic        in_sets_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output e_kind       out_kind,
    output logic        out_squash,
    input  logic        flags_wr_valid,
    input  logic [3:0]  flags_wr,
    input  logic        flush,
    output logic [3:0]  flags
);
    localparam int PW = 3;
    localparam logic [PW-1:0] MAXP = PW'(MAX_PENDING);

    typedef struct packed {
        logic [31:0] instr;
        e_kind       kind;
        e_cond       cond;
        logic        sets_flags;
    } entry_t;

    entry_t          r_mem [2];
    logic            r_rd;
    logic            r_wr;
    logic [1:0]      r_count;
    logic [PW-1:0]   r_pending;
    logic [3:0]      r_flags;

    entry_t          w_head;
    logic            w_nonempty;
    logic            w_uncond;
    logic            w_wait;
    logic            w_eval;
    logic            w_pass;
    logic            w_block;
    logic            w_push;
    logic            w_pop;
    logic            w_inc;

    // Flags are packed {N,Z,C,V}.
    function automatic logic cond_pass(input e_cond c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            C_EQ:    cond_pass = z;
            C_NE:    cond_pass = !z;
            C_CS:    cond_pass = cf;
            C_CC:    cond_pass = !cf;
            C_MI:    cond_pass = n;
            C_PL:    cond_pass = !n;
            C_VS:    cond_pass = v;
            C_VC:    cond_pass = !v;
            C_HI:    cond_pass = cf && !z;
            C_LS:    cond_pass = !cf || z;
            C_GE:    cond_pass = (n == v);
            C_LT:    cond_pass = (n != v);
            C_GT:    cond_pass = !z && (n == v);
            C_LE:    cond_pass = z || (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    assign w_head     = r_mem[r_rd];
    assign w_nonempty = (r_count != 2'd0);
    assign w_uncond   = (w_head.cond == C_AL) || (w_head.cond == C_NV);
    assign w_wait     = w_nonempty &&
                        ((!w_uncond && (r_pending != '0)) ||
                         (w_head.sets_flags && (r_pending == MAXP)));
    assign w_eval     = w_nonempty && !w_wait;
    assign w_pass     = cond_pass(w_head.cond, r_flags);
    assign w_block    = reset || flush;

    assign out_valid       = w_eval && w_pass && !w_block;
    assign out_squash      = w_eval && !w_pass && !w_block;
    assign out_instruction = w_nonempty ? w_head.instr : 32'h0;
    assign out_kind        = w_nonempty ? w_head.kind : K_ALU;
    assign in_ready        = !reset && !flush && (r_count != 2'd2);
    assign flags           = r_flags;

    assign w_push = in_valid && in_ready;
    assign w_pop  = (out_valid && out_ready) || out_squash;
    assign w_inc  = out_valid && out_ready && w_head.sets_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 2'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_pending <= '0;
            r_flags   <= 4'b0000;
        end else begin
            if (flags_wr_valid) begin
                r_flags <= flags_wr;
            end
            // A write-back with nothing outstanding saturates at zero.
            if (w_inc && !flags_wr_valid) begin
                r_pending <= r_pending + PW'(1);
            end else if (!w_inc && flags_wr_valid && (r_pending != '0)) begin
                r_pending <= r_pending - PW'(1);
            end
            if (flush) begin
                r_count <= 2'd0;
                r_rd    <= 1'b0;
                r_wr    <= 1'b0;
            end else begin
                if (w_push) r_wr <= ~r_wr;
                if (w_pop)  r_rd <= ~r_rd;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= '{instr: in_instruction, kind: in_kind,
                             cond: in_cond, sets_flags: in_sets_flags};
        end
    end
endmodule

// File: tb/tb_m_cond_issue.sv
// Bench for m_cond_issue: directed vector table, hand-written corner sequences,
// then random traffic compared against a queue-based reference model.
module tb_m_cond_issue;
    import m_cond_issue_pkg::*;

    localparam int MAXP = 3;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    e_kind       in_kind;
    e_cond       in_cond;
    logic        in_sets_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    e_kind       out_kind;
    logic        out_squash;
    logic        flags_wr_valid;
    logic [3:0]  flags_wr;
    logic        flush;
    logic [3:0]  flags;

    m_cond_issue #(.MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_kind(in_kind),
        .in_cond(in_cond), .in_sets_flags(in_sets_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_kind(out_kind),
        .out_squash(out_squash),
        .flags_wr_valid(flags_wr_valid), .flags_wr(flags_wr),
        .flush(flush), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, iv;
        logic [31:0] ins;
        logic [3:0]  cond;
        logic        sets, ordy, fwv;
        logic [3:0]  fw;
        logic        fl;
        logic        eov, esq, eir, ci;
        logic [31:0] eins;
        logic [3:0]  eflags;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        e_kind       kind;
        logic [3:0]  cond;
        logic        sets;
    } ent_t;

    int n_total = 0;
    int n_pass  = 0;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic rst, input logic iv, input logic [31:0] ins,
                                input logic [3:0] cond, input logic sets, input logic ordy,
                                input logic fwv, input logic [3:0] fw, input logic fl,
                                input logic eov, input logic esq, input logic eir,
                                input logic ci, input logic [31:0] eins, input logic [3:0] eflags);
        vec_t v;
        v = '{rst: rst, iv: iv, ins: ins, cond: cond, sets: sets, ordy: ordy, fwv: fwv,
              fw: fw, fl: fl, eov: eov, esq: esq, eir: eir, ci: ci, eins: eins, eflags: eflags};
        return v;
    endfunction

    // Directed cycle: drive, check mid-cycle, then cross the clock edge.
    task automatic apply(input vec_t v, input string nm);
        reset = v.rst; in_valid = v.iv; in_instruction = v.ins; in_kind = K_MUL;
        in_cond = e_cond'(v.cond); in_sets_flags = v.sets; out_ready = v.ordy;
        flags_wr_valid = v.fwv; flags_wr = v.fw; flush = v.fl;
        #3;
        check({nm, " out_valid"}, 32'(out_valid), 32'(v.eov));
        check({nm, " out_squash"}, 32'(out_squash), 32'(v.esq));
        check({nm, " in_ready"}, 32'(in_ready), 32'(v.eir));
        check({nm, " flags"}, 32'(flags), 32'(v.eflags));
        if (v.eov) begin
            check({nm, " out_instruction"}, out_instruction, v.eins);
            check({nm, " out_kind"}, 32'(out_kind), 32'(K_MUL));
        end else if (v.ci) begin
            check({nm, " out_instruction"}, out_instruction, 32'h0);
            check({nm, " out_kind"}, 32'(out_kind), 32'(K_ALU));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic seq_max_pending();
        apply(mk(L,H,32'hE2500011,4'hE,H,H,L,4'h0,L, L,L,H,L,32'h0,4'h0), "maxA1");
        apply(mk(L,H,32'hE2500012,4'hE,H,H,L,4'h0,L, H,L,H,L,32'hE2500011,4'h0), "maxA2");
        apply(mk(L,H,32'hE2500013,4'hE,H,H,L,4'h0,L, H,L,H,L,32'hE2500012,4'h0), "maxA3");
        apply(mk(L,H,32'hE2500014,4'hE,H,H,L,4'h0,L, H,L,H,L,32'hE2500013,4'h0), "maxA4");
        apply(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, L,L,H,L,32'h0,4'h0), "maxA5_wait");
        apply(mk(L,L,32'h0,4'hE,L,H,H,4'h1,L, L,L,H,L,32'h0,4'h0), "maxA6_wait");
        apply(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, H,L,H,L,32'hE2500014,4'h1), "maxA7");
        apply(mk(L,L,32'h0,4'hE,L,H,H,4'h0,L, L,L,H,L,32'h0,4'h1), "maxA8");
        apply(mk(L,L,32'h0,4'hE,L,H,H,4'h0,L, L,L,H,L,32'h0,4'h0), "maxA9");
        apply(mk(L,L,32'h0,4'hE,L,H,H,4'h0,L, L,L,H,L,32'h0,4'h0), "maxA10");
        // Write-back in the same cycle as the third issue keeps the count at two.
        apply(mk(L,H,32'hE2500015,4'hE,H,H,L,4'h0,L, L,L,H,L,32'h0,4'h0), "maxB1");
        apply(mk(L,H,32'hE2500016,4'hE,H,H,L,4'h0,L, H,L,H,L,32'hE2500015,4'h0), "maxB2");
        apply(mk(L,H,32'hE2500017,4'hE,H,H,L,4'h0,L, H,L,H,L,32'hE2500016,4'h0), "maxB3");
        apply(mk(L,H,32'hE2500018,4'hE,H,H,H,4'h8,L, H,L,H,L,32'hE2500017,4'h0), "maxB4");
        apply(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, H,L,H,L,32'hE2500018,4'h8), "maxB5");
    endtask

    task automatic seq_flush_reset();
        apply(mk(L,H,32'hE3A00010,4'hE,L,L,L,4'h0,L, L,L,H,L,32'h0,4'h8), "flC1");
        apply(mk(L,H,32'hE3A00011,4'hE,L,L,L,4'h0,L, H,L,H,L,32'hE3A00010,4'h8), "flC2");
        apply(mk(L,L,32'h0,4'hE,L,L,L,4'h0,L, H,L,L,L,32'hE3A00010,4'h8), "flC3_full");
        apply(mk(L,H,32'hE3A000FF,4'hE,L,H,H,4'hA,H, L,L,L,L,32'h0,4'h8), "flC4_flush");
        apply(mk(L,H,32'h0A000020,4'h0,L,H,L,4'h0,L, L,L,H,L,32'h0,4'hA), "flC5");
        apply(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, L,L,H,L,32'h0,4'hA), "flC6_wait");
        apply(mk(L,H,32'hE3A00021,4'hE,L,H,L,4'h0,L, L,L,H,L,32'h0,4'hA), "flC7_wait");
        apply(mk(H,L,32'h0,4'hE,L,H,L,4'h0,L, L,L,L,L,32'h0,4'hA), "rsC8");
        apply(mk(L,L,32'h0,4'hE,L,H,H,4'h6,L, L,L,H,H,32'h0,4'h0), "rsC9");
        apply(mk(L,H,32'h0A000030,4'h0,L,H,L,4'h0,L, L,L,H,L,32'h0,4'h6), "rsC10");
        apply(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, H,L,H,L,32'h0A000030,4'h6), "rsC11");
    endtask

    task automatic run_random(input int cycles);
        ent_t       mq[$];
        ent_t       hd;
        int         m_pend;
        logic [3:0] m_flags;
        logic       rst, iv, ordy, fwv, fl, sets, has, waitc, pass, e_ov, e_sq, e_ir, inc;
        logic [31:0] ins;
        logic [3:0] cond, fw;
        e_kind      kind;
        m_pend = 0;
        m_flags = 4'h0;
        for (int c = 0; c < cycles; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            fl   = ($urandom_range(0, 29) == 0);
            iv   = ($urandom_range(0, 9) < 6);
            ordy = ($urandom_range(0, 9) < 7);
            fwv  = ($urandom_range(0, 4) == 0);
            fw   = 4'($urandom_range(0, 15));
            ins  = $urandom;
            kind = e_kind'($urandom_range(0, 4));
            cond = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            sets = ($urandom_range(0, 9) < 4);
            reset = rst; in_valid = iv; in_instruction = ins; in_kind = kind;
            in_cond = e_cond'(cond); in_sets_flags = sets; out_ready = ordy;
            flags_wr_valid = fwv; flags_wr = fw; flush = fl;
            #3;
            hd = '{ins: 32'h0, kind: K_ALU, cond: 4'hE, sets: 1'b0};
            has = (mq.size() > 0);
            if (has) hd = mq[0];
            waitc = has && ((!(hd.cond inside {4'hE, 4'hF}) && m_pend > 0) ||
                            (hd.sets && m_pend == MAXP));
            pass  = cond_ok(hd.cond, m_flags);
            e_ov  = !rst && !fl && has && !waitc && pass;
            e_sq  = !rst && !fl && has && !waitc && !pass;
            e_ir  = !rst && !fl && (mq.size() < 2);
            check($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(e_ov));
            check($sformatf("rnd%0d out_squash", c), 32'(out_squash), 32'(e_sq));
            check($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(e_ir));
            check($sformatf("rnd%0d flags", c), 32'(flags), 32'(m_flags));
            if (e_ov) begin
                check($sformatf("rnd%0d out_instruction", c), out_instruction, hd.ins);
                check($sformatf("rnd%0d out_kind", c), 32'(out_kind), 32'(hd.kind));
            end
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_pend = 0;
                m_flags = 4'h0;
            end else begin
                inc = e_ov && ordy && hd.sets;
                if (fwv) m_flags = fw;
                if (inc && fwv) m_pend = m_pend;
                else if (inc) m_pend++;
                else if (fwv && m_pend > 0) m_pend--;
                if (fl) mq.delete();
                else begin
                    if ((e_ov && ordy) || e_sq) void'(mq.pop_front());
                    if (iv && e_ir) mq.push_back('{ins: ins, kind: kind, cond: cond, sets: sets});
                end
            end
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instruction = 32'h0; in_kind = K_ALU;
        in_cond = C_AL; in_sets_flags = 1'b0; out_ready = 1'b0;
        flags_wr_valid = 1'b0; flags_wr = 4'h0; flush = 1'b0;
        @(posedge clk);
        #1;

        tbl.push_back(mk(H,L,32'h0,4'hE,L,L,L,4'h0,L, L,L,L,H,32'h0,4'h0));
        tbl.push_back(mk(L,H,32'hE3A00001,4'hE,L,H,L,4'h0,L, L,L,H,H,32'h0,4'h0));
        tbl.push_back(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, H,L,H,L,32'hE3A00001,4'h0));
        tbl.push_back(mk(L,L,32'h0,4'hE,L,H,H,4'h4,L, L,L,H,L,32'h0,4'h0));
        tbl.push_back(mk(L,H,32'h03A00002,4'h0,L,H,L,4'h0,L, L,L,H,L,32'h0,4'h4));
        tbl.push_back(mk(L,H,32'h13A00003,4'h1,L,H,L,4'h0,L, H,L,H,L,32'h03A00002,4'h4));
        tbl.push_back(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, L,H,H,L,32'h0,4'h4));
        tbl.push_back(mk(L,H,32'hE2500001,4'hE,H,H,L,4'h0,L, L,L,H,L,32'h0,4'h4));
        tbl.push_back(mk(L,H,32'hC3A00004,4'hC,L,H,L,4'h0,L, H,L,H,L,32'hE2500001,4'h4));
        tbl.push_back(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, L,L,H,L,32'h0,4'h4));
        tbl.push_back(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, L,L,H,L,32'h0,4'h4));
        tbl.push_back(mk(L,L,32'h0,4'hE,L,H,H,4'h0,L, L,L,H,L,32'h0,4'h4));
        tbl.push_back(mk(L,L,32'h0,4'hE,L,H,L,4'h0,L, H,L,H,L,32'hC3A00004,4'h0));
        tbl.push_back(mk(L,L,32'h0,4'hE,L,L,L,4'h0,L, L,L,H,L,32'h0,4'h0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

        seq_max_pending();
        seq_flush_reset();

        apply(mk(H,L,32'h0,4'hE,L,L,L,4'h0,L, L,L,L,L,32'h0,4'h6), "rnd_reset");
        run_random(1500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
